// File: rtl/fractal_sync_pair_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fractal_sync_pair_ctrl
//  Purpose  : Pairs the two child rx FIFO heads of a sync tree node and either
//             forwards a merged request upward or wakes both children.
//  Revision : 1.0
// ============================================================================
module fractal_sync_pair_ctrl #(
    parameter int unsigned LVL_W   = 2,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            empty_i,
    input  logic [1:0][LVL_W-1:0] level_i,
    input  logic [1:0][ID_W-1:0]  id_i,
    input  logic [1:0]            root_i,
    output logic [1:0]            pop_o,
    output logic                  up_valid_o,
    input  logic                  up_ready_i,
    output logic [LVL_W-1:0]      up_level_o,
    output logic [ID_W-1:0]       up_id_o,
    output logic [1:0]            wake_o,
    output logic [LVL_W-1:0]      wake_level_o,
    output logic [ID_W-1:0]       wake_id_o,
    input  logic                  err_clr_i,
    output logic                  err_timeout_o,
    output logic                  err_mismatch_o,
    output logic [CNT_W-1:0]      sync_cnt_o
);

    localparam int unsigned c_wait_w = (TIMEOUT == 0) ? 1 :
                                       (($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1));
    localparam logic [c_wait_w-1:0] c_timeout_last =
        (TIMEOUT == 0) ? '0 : c_wait_w'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FWD  = 2'd2,
        ST_WAKE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [LVL_W-1:0]    r_level;
    logic [ID_W-1:0]     r_id;
    logic                r_err_timeout;
    logic                r_err_mismatch;
    logic [CNT_W-1:0]    r_sync_cnt;

    logic w_both;
    logic w_one;
    logic w_match;
    logic w_root;
    logic w_timeout_hit;
    logic w_capture;
    logic w_cnt_clr;
    logic w_set_timeout;
    logic w_set_mismatch;
    logic w_sync_inc;

    assign w_both        = (empty_i == 2'b00);
    assign w_one         = ^empty_i;
    assign w_match       = (level_i[0] == level_i[1]) && (id_i[0] == id_i[1]);
    assign w_root        = |root_i;
    assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == c_timeout_last);

    // Combinational strobes are held off while reset is asserted so an
    // interrupted handshake never pops a FIFO.
    always_comb begin
        w_state_nxt    = r_state;
        pop_o          = 2'b00;
        wake_o         = 2'b00;
        up_valid_o     = 1'b0;
        w_capture      = 1'b0;
        w_cnt_clr      = 1'b0;
        w_set_timeout  = 1'b0;
        w_set_mismatch = 1'b0;
        w_sync_inc     = 1'b0;
        if (rst_ni) begin
            case (r_state)
                ST_IDLE, ST_WAIT: begin
                    if (w_both) begin
                        if (w_match) begin
                            w_capture   = 1'b1;
                            w_state_nxt = w_root ? ST_WAKE : ST_FWD;
                        end else begin
                            pop_o          = 2'b11;
                            w_set_mismatch = 1'b1;
                            w_state_nxt    = ST_IDLE;
                        end
                    end else if (r_state == ST_IDLE) begin
                        if (w_one) begin
                            w_state_nxt = ST_WAIT;
                            w_cnt_clr   = 1'b1;
                        end
                    end else if (!w_one) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_timeout_hit) begin
                        pop_o         = ~empty_i;
                        w_set_timeout = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end
                end
                ST_FWD: begin
                    up_valid_o = 1'b1;
                    if (up_ready_i) begin
                        pop_o       = 2'b11;
                        w_sync_inc  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_WAKE: begin
                    wake_o      = 2'b11;
                    pop_o       = 2'b11;
                    w_sync_inc  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state        <= ST_IDLE;
            r_wait_cnt     <= '0;
            r_level        <= '0;
            r_id           <= '0;
            r_err_timeout  <= 1'b0;
            r_err_mismatch <= 1'b0;
            r_sync_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cnt_clr) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_capture) begin
                r_level <= level_i[0];
                r_id    <= id_i[0];
            end
            // A new error event in the clear cycle must not be lost.
            r_err_timeout  <= w_set_timeout  | (r_err_timeout  & ~err_clr_i);
            r_err_mismatch <= w_set_mismatch | (r_err_mismatch & ~err_clr_i);
            if (w_sync_inc && (r_sync_cnt != c_cnt_max)) begin
                r_sync_cnt <= r_sync_cnt + 1'b1;
            end
        end
    end

    assign up_level_o     = r_level;
    assign up_id_o        = r_id;
    assign wake_level_o   = r_level;
    assign wake_id_o      = r_id;
    assign err_timeout_o  = r_err_timeout;
    assign err_mismatch_o = r_err_mismatch;
    assign sync_cnt_o     = r_sync_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fractal_sync_pair_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fractal_sync_pair_ctrl
//  Purpose  : Directed and random stimulus for fractal_sync_pair_ctrl against
//             a request-level reference model with child FIFO queues.
//  Revision : 1.0
// ============================================================================
module tb_fractal_sync_pair_ctrl;

    localparam int LVL_W   = 2;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;

    typedef struct packed {
        logic [LVL_W-1:0] lvl;
        logic [ID_W-1:0]  id;
        logic             root;
    } req_t;

    logic                  clk = 1'b0;
    logic                  rst_ni = 1'b0;
    logic [1:0]            empty_i = 2'b11;
    logic [1:0][LVL_W-1:0] level_i = '0;
    logic [1:0][ID_W-1:0]  id_i = '0;
    logic [1:0]            root_i = '0;
    logic [1:0]            pop_o;
    logic                  up_valid_o;
    logic                  up_ready_i = 1'b0;
    logic [LVL_W-1:0]      up_level_o;
    logic [ID_W-1:0]       up_id_o;
    logic [1:0]            wake_o;
    logic [LVL_W-1:0]      wake_level_o;
    logic [ID_W-1:0]       wake_id_o;
    logic                  err_clr_i = 1'b0;
    logic                  err_timeout_o;
    logic                  err_mismatch_o;
    logic [CNT_W-1:0]      sync_cnt_o;

    fractal_sync_pair_ctrl #(
        .LVL_W  (LVL_W),
        .ID_W   (ID_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .empty_i       (empty_i),
        .level_i       (level_i),
        .id_i          (id_i),
        .root_i        (root_i),
        .pop_o         (pop_o),
        .up_valid_o    (up_valid_o),
        .up_ready_i    (up_ready_i),
        .up_level_o    (up_level_o),
        .up_id_o       (up_id_o),
        .wake_o        (wake_o),
        .wake_level_o  (wake_level_o),
        .wake_id_o     (wake_id_o),
        .err_clr_i     (err_clr_i),
        .err_timeout_o (err_timeout_o),
        .err_mismatch_o(err_mismatch_o),
        .sync_cnt_o    (sync_cnt_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Child FIFO contents and the reference view of the node.
    req_t q0[$];
    req_t q1[$];
    int               m_age     = -1;   // cycles a lone head has been waiting, -1 = none
    bit               m_fwd     = 1'b0; // merged request owed to the parent
    bit               m_wake    = 1'b0; // wake owed to the children
    logic [LVL_W-1:0] m_lvl     = '0;
    logic [ID_W-1:0]  m_id      = '0;
    bit               m_terr    = 1'b0;
    bit               m_merr    = 1'b0;
    int               m_cnt     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive_heads();
        empty_i[0] = (q0.size() == 0);
        empty_i[1] = (q1.size() == 0);
        level_i    = LVL_W'($urandom) | '0;
        level_i[0] = (q0.size() != 0) ? q0[0].lvl  : LVL_W'($urandom);
        level_i[1] = (q1.size() != 0) ? q1[0].lvl  : LVL_W'($urandom);
        id_i[0]    = (q0.size() != 0) ? q0[0].id   : ID_W'($urandom);
        id_i[1]    = (q1.size() != 0) ? q1[0].id   : ID_W'($urandom);
        root_i[0]  = (q0.size() != 0) ? q0[0].root : 1'($urandom);
        root_i[1]  = (q1.size() != 0) ? q1[0].root : 1'($urandom);
    endtask

    task automatic tick();
        logic [1:0] e_pop;
        logic [1:0] e_wake;
        logic       e_valid;
        bit         set_t, set_m, inc, cap, n_fwd, n_wake, have0, have1;
        int         n_age;
        drive_heads();
        have0 = (q0.size() != 0);
        have1 = (q1.size() != 0);
        e_pop = 2'b00; e_wake = 2'b00; e_valid = 1'b0;
        set_t = 0; set_m = 0; inc = 0; cap = 0;
        n_fwd = m_fwd; n_wake = m_wake; n_age = m_age;
        if (rst_ni) begin
            if (m_wake) begin
                e_wake = 2'b11; e_pop = 2'b11; inc = 1; n_wake = 0;
            end else if (m_fwd) begin
                e_valid = 1'b1;
                if (up_ready_i) begin
                    e_pop = 2'b11; inc = 1; n_fwd = 0;
                end
            end else if (have0 && have1) begin
                n_age = -1;
                if (q0[0].lvl == q1[0].lvl && q0[0].id == q1[0].id) begin
                    cap = 1;
                    if (q0[0].root || q1[0].root) n_wake = 1;
                    else n_fwd = 1;
                end else begin
                    e_pop = 2'b11; set_m = 1;
                end
            end else if (have0 || have1) begin
                if (m_age < 0) n_age = 0;
                else if (TIMEOUT != 0 && m_age == TIMEOUT - 1) begin
                    e_pop = {have1, have0}; set_t = 1; n_age = -1;
                end else n_age = m_age + 1;
            end else begin
                n_age = -1;
            end
        end
        @(negedge clk);
        chk("pop", 32'(pop_o), 32'(e_pop));
        chk("wake", 32'(wake_o), 32'(e_wake));
        chk("up_valid", 32'(up_valid_o), 32'(e_valid));
        if (e_valid) begin
            chk("up_level", 32'(up_level_o), 32'(m_lvl));
            chk("up_id", 32'(up_id_o), 32'(m_id));
        end
        if (e_wake != 2'b00) begin
            chk("wake_level", 32'(wake_level_o), 32'(m_lvl));
            chk("wake_id", 32'(wake_id_o), 32'(m_id));
        end
        chk("err_timeout", 32'(err_timeout_o), 32'(m_terr));
        chk("err_mismatch", 32'(err_mismatch_o), 32'(m_merr));
        chk("sync_cnt", 32'(sync_cnt_o), 32'(m_cnt));
        @(posedge clk);
        if (!rst_ni) begin
            m_age = -1; m_fwd = 0; m_wake = 0; m_lvl = '0; m_id = '0;
            m_terr = 0; m_merr = 0; m_cnt = 0;
        end else begin
            if (cap) begin
                m_lvl = q0[0].lvl;
                m_id  = q0[0].id;
            end
            if (e_pop[0]) void'(q0.pop_front());
            if (e_pop[1]) void'(q1.pop_front());
            m_age = n_age; m_fwd = n_fwd; m_wake = n_wake;
            m_terr = set_t | (m_terr & !err_clr_i);
            m_merr = set_m | (m_merr & !err_clr_i);
            if (inc && m_cnt < (2 ** CNT_W) - 1) m_cnt++;
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic req_t mk(input int lvl, input int id, input bit root);
        req_t r;
        r.lvl  = LVL_W'(lvl);
        r.id   = ID_W'(id);
        r.root = root;
        return r;
    endfunction

    initial begin
        req_t a;
        req_t b;
        int   r;
        drive_heads();
        @(posedge clk);
        #1;
        tick();
        rst_ni = 1'b1;
        chk("reset_sync_cnt", 32'(sync_cnt_o), 32'd0);
        chk("reset_err_timeout", 32'(err_timeout_o), 32'd0);

        // Non-root pair with the parent always ready.
        up_ready_i = 1'b1;
        q0.push_back(mk(2, 1, 0)); q1.push_back(mk(2, 1, 0));
        run(3);
        chk("fwd_sync_cnt", 32'(sync_cnt_o), 32'd1);

        // Parent back-pressure for several cycles.
        up_ready_i = 1'b0;
        q0.push_back(mk(2, 1, 0)); q1.push_back(mk(2, 1, 0));
        run(6);
        up_ready_i = 1'b1;
        run(3);
        chk("bp_sync_cnt", 32'(sync_cnt_o), 32'd2);

        // Root pair wakes both children.
        q0.push_back(mk(1, 0, 1)); q1.push_back(mk(1, 0, 0));
        run(3);
        chk("root_sync_cnt", 32'(sync_cnt_o), 32'd3);

        // Lone child 1 times out and is dropped.
        q1.push_back(mk(3, 2, 0));
        run(6);
        chk("timeout_flag", 32'(err_timeout_o), 32'd1);
        chk("timeout_q1_drained", 32'(empty_i), 32'd3);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        tick();
        chk("timeout_cleared", 32'(err_timeout_o), 32'd0);

        // Partner shows up three cycles late, still within the timeout.
        q0.push_back(mk(0, 3, 0));
        run(3);
        q1.push_back(mk(0, 3, 0));
        run(4);
        chk("late_no_timeout", 32'(err_timeout_o), 32'd0);
        chk("late_sync_cnt", 32'(sync_cnt_o), 32'd4);

        // Mismatched heads are both dropped.
        q0.push_back(mk(2, 0, 0)); q1.push_back(mk(2, 1, 0));
        run(2);
        chk("mismatch_flag", 32'(err_mismatch_o), 32'd1);
        chk("mismatch_sync_cnt", 32'(sync_cnt_o), 32'd4);

        // Reset while a forward is stalled at the parent.
        up_ready_i = 1'b0;
        q0.push_back(mk(1, 2, 0)); q1.push_back(mk(1, 2, 0));
        run(2);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk("rst_up_valid", 32'(up_valid_o), 32'd0);
        chk("rst_pop", 32'(pop_o), 32'd0);
        chk("rst_sync_cnt", 32'(sync_cnt_o), 32'd0);
        chk("rst_err_mismatch", 32'(err_mismatch_o), 32'd0);
        chk("rst_up_level", 32'(up_level_o), 32'd0);
        up_ready_i = 1'b1;
        run(3);

        // Back-to-back root syncs drive the counter into saturation.
        for (int i = 0; i < 10; i++) begin
            q0.push_back(mk(i % 4, (i + 1) % 4, 1));
            q1.push_back(mk(i % 4, (i + 1) % 4, 0));
        end
        run(22);
        chk("sat_sync_cnt", 32'(sync_cnt_o), 32'd7);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            if (q0.size() < 3 && q1.size() < 3) begin
                a = mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
                b = a;
                b.root = 1'($urandom);
                if (r < 25) begin
                    q0.push_back(a); q1.push_back(b);
                end else if (r < 30) begin
                    b.id = a.id ^ ID_W'($urandom_range(1, 3));
                    q0.push_back(a); q1.push_back(b);
                end else if (r < 33) begin
                    q0.push_back(a);
                end else if (r < 36) begin
                    q1.push_back(b);
                end
            end
            up_ready_i = ($urandom_range(0, 3) != 0);
            err_clr_i  = ($urandom_range(0, 19) == 0);
            rst_ni     = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_ni = 1'b1;
        err_clr_i = 1'b0;
        run(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
